store_narrow: RTL and testbench

STORE_NARROW -- requirements
Module: store_narrow

---
 rtl/mem_pkg.sv | 35 +++
 rtl/store_lane_map.sv | 61 ++++++
 rtl/store_narrow.sv | 100 ++++++++++
 tb/tb_store_narrow.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared store-path types: size encoding, buffered write entry and the alignment rule.
// The STORE_MISALIGN_TRAP_EN build option is consumed by store_lane_map, not here.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        misalign;
    } store_entry_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Reserved sizes are treated like words, so they share the word alignment rule.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            SZ_RSVD: bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_map.sv
// Combinational mapper from (size, address, register value) to a buffered write entry.
// Define STORE_MISALIGN_TRAP_EN to suppress byte enables of misaligned stores.
module store_lane_map
    import mem_pkg::*;
(
    input  logic [31:0]  addr_i,
    input  logic [31:0]  data_i,
    input  logic [1:0]   size_i,
    output store_entry_t entry_o
);

    size_e       size;
    logic        misalign;
    logic [1:0]  lo;
    logic [3:0]  be;
    logic [31:0] data;

    assign size     = size_e'(size_i);
    assign lo       = addr_i[1:0];
    assign misalign = is_misaligned(size, lo);

    // Lanes are chosen from the naturally aligned address, so a misaligned half
    // lands in the half that contains it and a misaligned word covers the whole word.
    always_comb begin
        be   = 4'b0000;
        data = data_i;
        case (size)
            SZ_BYTE: begin
                be   = 4'b0001 << lo;
                data = {4{data_i[7:0]}};
            end
            SZ_HALF: begin
                be   = lo[1] ? 4'b1100 : 4'b0011;
                data = {2{data_i[15:0]}};
            end
            SZ_WORD: begin
                be   = 4'b1111;
                data = data_i;
            end
            SZ_RSVD: begin
                be   = 4'b1111;
                data = data_i;
            end
            default: begin
                be   = 4'b0000;
                data = data_i;
            end
        endcase
`ifdef STORE_MISALIGN_TRAP_EN
        if (misalign) begin
            be = 4'b0000;
        end
`endif
    end

    assign entry_o.addr     = {addr_i[31:2], 2'b00};
    assign entry_o.data     = data;
    assign entry_o.be       = be;
    assign entry_o.misalign = misalign;

endmodule

// File: rtl/store_narrow.sv
// Store narrowing buffer: maps sub-word stores to byte-enabled word writes and queues them.
// Optional build macro STORE_MISALIGN_TRAP_EN (see store_lane_map) blanks misaligned writes.
module store_narrow
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [3:0]  out_be,
    output logic        out_misalign,
    output logic [7:0]  err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    store_entry_t     entry;
    store_entry_t     head;
    store_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       err_q, err_d;
    logic             push;
    logic             pop;

    store_lane_map u_lane_map (
        .addr_i  (in_addr),
        .data_i  (in_data),
        .size_i  (in_size),
        .entry_o (entry)
    );

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && entry.misalign && (err_q != ERR_COUNT_MAX)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    // Storage is not reset, so the qualifying outputs are gated with occupancy.
    assign head         = mem_q[rd_ptr_q];
    assign out_addr     = head.addr;
    assign out_data     = head.data;
    assign out_be       = out_valid ? head.be : 4'b0000;
    assign out_misalign = out_valid & head.misalign;
    assign err_count    = err_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow at its default DEPTH of 2.
// Expected byte enables for misaligned stores follow STORE_MISALIGN_TRAP_EN.
module tb_store_narrow;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_misalign;
    logic [7:0]  err_count;

    int total;
    int bad;

`ifdef STORE_MISALIGN_TRAP_EN
    localparam logic [3:0] BE_MIS_WORD = 4'b0000;
    localparam logic [3:0] BE_MIS_HALF = 4'b0000;
`else
    localparam logic [3:0] BE_MIS_WORD = 4'b1111;
    localparam logic [3:0] BE_MIS_HALF = 4'b1100;
`endif

    store_narrow #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_size      (in_size),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_be       (out_be),
        .out_misalign (out_misalign),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        in_valid = 1'b1;
        in_addr  = addr;
        in_data  = data;
        in_size  = size;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkHead(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic mis);
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, ".addr"}, out_addr, addr);
        checkOutput({tag, ".data"}, out_data, data);
        checkOutput({tag, ".be"}, {28'd0, out_be}, {28'd0, be});
        checkOutput({tag, ".mis"}, {31'd0, out_misalign}, {31'd0, mis});
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_size   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst.be", {28'd0, out_be}, 32'd0);
        checkOutput("rst.mis", {31'd0, out_misalign}, 32'd0);
        checkOutput("rst.err", {24'd0, err_count}, 32'd0);

        // Byte store, one-cycle latency to the outputs.
        applyStimulus(32'h0000_1003, 32'hA1B2_C3D4, 2'b00);
        checkHead("byte", 32'h0000_1000, 32'hD4D4_D4D4, 4'b1000, 1'b0);
        popOne();
        checkOutput("byte.empty", {31'd0, out_valid}, 32'd0);

        applyStimulus(32'h0000_2002, 32'h0000_BEEF, 2'b01);
        checkHead("half", 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b0);
        popOne();

        applyStimulus(32'h0000_3001, 32'h1234_5678, 2'b10);
        checkHead("wmis", 32'h0000_3000, 32'h1234_5678, BE_MIS_WORD, 1'b1);
        checkOutput("wmis.err", {24'd0, err_count}, 32'd1);
        popOne();

        applyStimulus(32'h0000_4003, 32'h0000_CAFE, 2'b01);
        checkHead("hmis", 32'h0000_4000, 32'hCAFE_CAFE, BE_MIS_HALF, 1'b1);
        checkOutput("hmis.err", {24'd0, err_count}, 32'd2);
        popOne();

        applyStimulus(32'h0000_5000, 32'hDEAD_BEEF, 2'b11);
        checkHead("rsvd", 32'h0000_5000, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        checkOutput("rsvd.err", {24'd0, err_count}, 32'd2);
        popOne();

        applyStimulus(32'h0000_6001, 32'h0000_0055, 2'b00);
        checkHead("byte1", 32'h0000_6000, 32'h5555_5555, 4'b0010, 1'b0);
        popOne();

        // Backpressure: fill, hold a third request, release one slot.
        applyStimulus(32'h0000_7000, 32'h1111_1111, 2'b10);
        applyStimulus(32'h0000_7004, 32'h2222_2222, 2'b10);
        checkOutput("bp.full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_addr  = 32'h0000_7008;
        in_data  = 32'h3333_3333;
        in_size  = 2'b10;
        tick();
        checkHead("bp.hold", 32'h0000_7000, 32'h1111_1111, 4'b1111, 1'b0);
        checkOutput("bp.stillfull", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp.slot", {31'd0, in_ready}, 32'd1);
        checkHead("bp.second", 32'h0000_7004, 32'h2222_2222, 4'b1111, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("bp.refull", {31'd0, in_ready}, 32'd0);
        popOne();
        checkHead("bp.third", 32'h0000_7008, 32'h3333_3333, 4'b1111, 1'b0);
        popOne();
        checkOutput("bp.empty", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop keeps occupancy at one.
        applyStimulus(32'h0000_8000, 32'h4444_4444, 2'b10);
        out_ready = 1'b1;
        applyStimulus(32'h0000_8004, 32'h5555_5555, 2'b10);
        checkHead("pp", 32'h0000_8004, 32'h5555_5555, 4'b1111, 1'b0);
        checkOutput("pp.ready", {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b0;
        checkOutput("pp.empty", {31'd0, out_valid}, 32'd0);

        // Streaming 300 misaligned words: count starts at 2 and saturates.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_addr   = 32'h0000_9001;
        in_data   = 32'h0BAD_F00D;
        in_size   = 2'b10;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 251) begin
                checkOutput("sat.254", {24'd0, err_count}, 32'd254);
            end
        end
        in_valid = 1'b0;
        checkOutput("sat.255", {24'd0, err_count}, 32'd255);
        tick();
        out_ready = 1'b0;
        checkOutput("sat.empty", {31'd0, out_valid}, 32'd0);

        // Reset with two buffered entries discards them.
        applyStimulus(32'h0000_A000, 32'hAAAA_AAAA, 2'b10);
        applyStimulus(32'h0000_A004, 32'hBBBB_BBBB, 2'b10);
        checkOutput("mid.full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid.ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid.err", {24'd0, err_count}, 32'd0);
        checkOutput("mid.be", {28'd0, out_be}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid.noemit", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;

        // A request offered while reset is high is not taken.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 32'h0000_B001;
        in_size  = 2'b10;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checkOutput("rstreq.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstreq.err", {24'd0, err_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
